byte_frame_parser: RTL and testbench

- Stage directly downstream of the serial-to-byte stream divider: consumes its byte bus, byte strobe and data-select flag.
- Hunts for a sync byte, reads a length byte, collects the payload, then checks an XOR checksum.
- Only frames whose checksum matches are released to the next stage over a valid/ready byte interface; bad or oversize frames are discarded.
- Payload is buffered in a commit/rollback FIFO, so the upstream side (which has no backpressure) never stalls.

---
 rtl/byte_frame_parser_pkg.sv | 40 ++++
 rtl/byte_frame_parser_if.sv | 41 ++++
 rtl/byte_frame_parser_fifo.sv | 88 ++++++++
 rtl/byte_frame_parser.sv | 189 ++++++++++++++++++
 tb/tb_byte_frame_parser.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_frame_parser_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : frame_pkg
// Description : Shared types and constants for the byte frame parser: parser
//               state encoding, error codes, default sync marker and the
//               FIFO word layout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package frame_pkg;

    // Parser states, one transition per accepted byte
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } state_e;

    // Error codes reported alongside frame_err
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    // Default frame start marker
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // One FIFO entry: end-of-frame flag above the payload byte
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_word_t;

    // Running XOR checksum step
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_frame_parser_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : byte_frame_parser_if
// Description : Byte stream bus of the frame parser. The input side carries
//               the stream-divider byte, strobe and data-select flag; the
//               output side is a valid/ready payload byte stream.
//               master = stream source / payload consumer, slave = parser.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface byte_frame_parser_if;

    logic [7:0] in_data;
    logic       in_ena;
    logic       in_sel;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data,
        output in_ena,
        output in_sel,
        output out_ready,
        input  out_data,
        input  out_last,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_ena,
        input  in_sel,
        input  out_ready,
        output out_data,
        output out_last,
        output out_valid
    );

endinterface
`default_nettype wire

// File: rtl/byte_frame_parser_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : frame_fifo
// Description : Commit/rollback FIFO. Writes advance a speculative write
//               pointer; entries become visible to the reader only once the
//               commit pointer is moved up to it. Rollback rewinds the write
//               pointer to the last commit without touching the read side.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module frame_fifo
    import frame_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        push,
    input  fifo_word_t din,
    input  wire        commit,
    input  wire        rollback,
    input  wire        pop,
    output logic       full,
    output logic       valid,
    output fifo_word_t dout
);

    // One extra pointer bit separates full from empty
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_P = (AW + 1)'(DEPTH);

    logic [AW:0] wr_ptr_q,     wr_ptr_d;
    logic [AW:0] commit_ptr_q, commit_ptr_d;
    logic [AW:0] rd_ptr_q,     rd_ptr_d;
    fifo_word_t  mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    // Occupancy includes uncommitted entries so speculative writes never
    // overrun data the reader has not consumed yet
    assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign valid     = (rd_ptr_q != commit_ptr_q);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & valid;

    // Show-ahead head word, forced to zero when nothing is committed
    assign dout = valid ? mem[rd_ptr_q[AW-1:0]] : '0;

    // Next-pointer computation; rollback wins over a write in the same cycle
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (rollback) begin
            wr_ptr_d = commit_ptr_q;
        end else if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (commit) begin
            commit_ptr_d = wr_ptr_q;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless until covered by the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_frame_parser.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : byte_frame_parser
// Description : Hunts for a sync byte, reads a length byte, buffers the
//               payload speculatively and checks an XOR checksum over the
//               length and payload. Good frames are committed and drained
//               over a valid/ready stream; bad or oversize frames are
//               rolled back and reported.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module byte_frame_parser
    import frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN   = 16,
    parameter int         DEPTH     = 32
) (
    input  wire                 clk,
    input  wire                 rst_n,
    byte_frame_parser_if.slave  bus,
    output logic                frame_ok,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic [15:0]         frame_cnt
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    // Internal reset: asserts immediately, releases two clocks after rst_n rises
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    // Parser registers
    state_e      state_q,     state_d;
    logic [7:0]  len_q,       len_d;
    logic [7:0]  idx_q,       idx_d;
    logic [7:0]  csum_q,      csum_d;
    logic        ovf_q,       ovf_d;
    logic        frame_ok_q,  frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q,  err_code_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // FIFO control
    logic        w_accept;
    logic        w_is_last;
    logic        w_push;
    logic        w_commit;
    logic        w_rollback;
    logic        w_fifo_full;
    logic        w_fifo_valid;
    fifo_word_t  w_din;
    fifo_word_t  w_dout;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    // Reset synchroniser: async assert, clocked release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign w_accept  = bus.in_ena & bus.in_sel;
    assign w_is_last = (idx_q == (len_q - 8'd1));
    assign w_din     = '{last: w_is_last, data: bus.in_data};

    // Next-state logic: one step per accepted byte, pulses default low
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        ovf_d       = ovf_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;
        w_push      = 1'b0;
        w_commit    = 1'b0;
        w_rollback  = 1'b0;
        if (w_accept) begin
            case (state_q)
                HUNT: begin
                    if (bus.in_data == SYNC_BYTE) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    len_d  = bus.in_data;
                    csum_d = bus.in_data;
                    idx_d  = 8'd0;
                    ovf_d  = 1'b0;
                    if (bus.in_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = HUNT;
                    end else if (bus.in_data == 8'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    csum_d = csum_step(csum_q, bus.in_data);
                    idx_d  = idx_q + 8'd1;
                    // A full FIFO drops the byte but framing keeps counting
                    if (w_fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                    if (w_is_last) begin
                        state_d = CSUM;
                    end
                end
                CSUM: begin
                    if ((bus.in_data == csum_q) && !ovf_q) begin
                        w_commit    = 1'b1;
                        frame_ok_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        w_rollback  = 1'b1;
                        frame_err_d = 1'b1;
                        err_code_d  = ovf_q ? ERR_OVF : ERR_CSUM;
                    end
                    state_d = HUNT;
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Parser state and registered status outputs
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= HUNT;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            csum_q      <= 8'd0;
            ovf_q       <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            ovf_q       <= ovf_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .push     (w_push),
        .din      (w_din),
        .commit   (w_commit),
        .rollback (w_rollback),
        .pop      (bus.out_ready),
        .full     (w_fifo_full),
        .valid    (w_fifo_valid),
        .dout     (w_dout)
    );

    assign bus.out_data  = w_dout.data;
    assign bus.out_last  = w_dout.last;
    assign bus.out_valid = w_fifo_valid;

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_frame_parser.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : tb_byte_frame_parser
// Description : Self-checking bench for byte_frame_parser. A frame-level
//               reference model tracks committed and pending payload and the
//               expected status outputs; a compare process checks the DUT
//               against it every cycle, and directed scenarios pin literal
//               values.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_byte_frame_parser;

    localparam int         MAX_LEN = 16;
    localparam int         DEPTH   = 32;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    byte_frame_parser_if bus_if ();

    byte_frame_parser #(
        .SYNC_BYTE (SYNC),
        .MAX_LEN   (MAX_LEN),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0]  m_fifo[$];   // committed, not yet popped {last,data}
    logic [8:0]  m_pend[$];   // payload of frame in progress
    logic [7:0]  m_rx[$];     // bytes of current frame, starting at sync
    bit          m_ovf = 1'b0;
    bit          e_ok  = 1'b0;
    bit          e_err = 1'b0;
    logic [1:0]  e_code = 2'd0;
    logic [15:0] e_cnt  = 16'd0;

    task automatic model_byte(input logic [7:0] b, input int occ);
        int         len;
        logic [7:0] x;
        if (m_rx.size() == 0) begin
            if (b == SYNC) m_rx.push_back(b);
            return;
        end
        m_rx.push_back(b);
        len = int'(m_rx[1]);
        if (m_rx.size() == 2) begin
            m_ovf = 1'b0;
            m_pend.delete();
            if (len > MAX_LEN) begin
                e_err  = 1'b1;
                e_code = 2'd2;
                m_rx.delete();
            end
            return;
        end
        if (m_rx.size() <= len + 2) begin
            if (occ >= DEPTH) m_ovf = 1'b1;
            else m_pend.push_back({(m_rx.size() == len + 2), b});
            return;
        end
        x = 8'h00;
        for (int i = 1; i <= len + 1; i++) x = x ^ m_rx[i];
        if (x == b && !m_ovf) begin
            foreach (m_pend[i]) m_fifo.push_back(m_pend[i]);
            e_ok  = 1'b1;
            e_cnt = e_cnt + 16'd1;
        end else begin
            e_err  = 1'b1;
            e_code = m_ovf ? 2'd3 : 2'd1;
        end
        m_pend.delete();
        m_rx.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_fifo.delete();
                m_pend.delete();
                m_rx.delete();
                m_ovf  = 1'b0;
                e_ok   = 1'b0;
                e_err  = 1'b0;
                e_code = 2'd0;
                e_cnt  = 16'd0;
            end else begin
                bit pop;
                int occ;
                pop   = (m_fifo.size() > 0) && bus_if.out_ready;
                occ   = m_fifo.size() + m_pend.size();
                e_ok  = 1'b0;
                e_err = 1'b0;
                if (bus_if.in_ena && bus_if.in_sel) model_byte(bus_if.in_data, occ);
                if (pop) void'(m_fifo.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(bus_if.out_valid), 32'(m_fifo.size() > 0));
            chk("out_data",  32'(bus_if.out_data),  (m_fifo.size() > 0) ? 32'(m_fifo[0][7:0]) : 32'd0);
            chk("out_last",  32'(bus_if.out_last),  (m_fifo.size() > 0) ? 32'(m_fifo[0][8])   : 32'd0);
            chk("frame_ok",  32'(frame_ok),  32'(e_ok));
            chk("frame_err", 32'(frame_err), 32'(e_err));
            chk("err_code",  32'(err_code),  32'(e_code));
            chk("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
        end
    end

    // ---------------- observed output stream ----------------
    logic [8:0] recv[$];
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && bus_if.out_valid && bus_if.out_ready)
                recv.push_back({bus_if.out_last, bus_if.out_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    bit         rnd_ready = 1'b0;
    logic [7:0] frm[$];

    task automatic tick();
        @(negedge clk);
        if (rnd_ready) bus_if.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b, input bit sel = 1'b1);
        bus_if.in_data = b;
        bus_if.in_ena  = 1'b1;
        bus_if.in_sel  = sel;
        tick();
        bus_if.in_ena  = 1'b0;
    endtask

    task automatic send_frm(input int gap);
        foreach (frm[i]) begin
            send(frm[i]);
            idle(gap);
        end
    endtask

    task automatic build(input int len, input int base);
        logic [7:0] x;
        frm.delete();
        frm.push_back(SYNC);
        frm.push_back(8'(len));
        x = 8'(len);
        for (int k = 0; k < len; k++) begin
            frm.push_back(8'(base + k));
            x = x ^ 8'(base + k);
        end
        frm.push_back(x);
    endtask

    task automatic drain();
        int n;
        bus_if.out_ready = 1'b1;
        n = 0;
        while (m_fifo.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(m_fifo.size()), 32'd0);
        idle(2);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int errs;
        int lasts;
        bus_if.in_data   = 8'h00;
        bus_if.in_ena    = 1'b0;
        bus_if.in_sel    = 1'b0;
        bus_if.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        idle(3);
        chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_cnt",   32'(frame_cnt), 32'd0);
        #2 rst_n = 1'b1;
        idle(4);

        // 1: good frame, continuous drain
        bus_if.out_ready = 1'b1;
        recv.delete();
        frm = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_frm(0);
        chk("t1_ok_pulse", 32'(frame_ok), 32'd1);
        chk("t1_head",     32'(bus_if.out_data), 32'h11);
        idle(4);
        chk("t1_cnt",  32'(frame_cnt), 32'd1);
        chk("t1_nrx",  32'(recv.size()), 32'd3);
        if (recv.size() == 3) begin
            chk("t1_b0", 32'(recv[0]), 32'h011);
            chk("t1_b1", 32'(recv[1]), 32'h022);
            chk("t1_b2", 32'(recv[2]), 32'h133);
        end

        // 2: bad checksum, then a lone good frame
        recv.delete();
        frm = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'hFF};
        send_frm(0);
        chk("t2_err",   32'(frame_err), 32'd1);
        chk("t2_code",  32'(err_code),  32'd1);
        chk("t2_valid", 32'(bus_if.out_valid), 32'd0);
        frm = '{8'hA5, 8'h01, 8'h5C, 8'h5D};
        send_frm(1);
        idle(3);
        chk("t2_nrx", 32'(recv.size()), 32'd1);
        if (recv.size() == 1) chk("t2_b0", 32'(recv[0]), 32'h15C);

        // 3: hunt drops noise, oversize length, resync
        frm = '{8'h00, 8'h7E, 8'hA5, 8'h11};
        send_frm(0);
        chk("t3_err",  32'(frame_err), 32'd1);
        chk("t3_code", 32'(err_code),  32'd2);
        frm = '{8'hA5, 8'h01, 8'h77, 8'h76};
        send_frm(0);
        chk("t3_ok", 32'(frame_ok), 32'd1);
        drain();
        chk("t3_cnt", 32'(frame_cnt), 32'd3);

        // 4: overflow under backpressure
        bus_if.out_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            build(16, f * 16);
            send_frm(0);
        end
        chk("t4_err",  32'(frame_err), 32'd1);
        chk("t4_code", 32'(err_code),  32'd3);
        chk("t4_cnt",  32'(frame_cnt), 32'd5);
        recv.delete();
        drain();
        chk("t4_nrx", 32'(recv.size()), 32'd32);
        errs  = 0;
        lasts = 0;
        foreach (recv[j]) begin
            if (recv[j][7:0] != 8'(j)) errs++;
            if (recv[j][8]) lasts++;
        end
        chk("t4_order", 32'(errs),  32'd0);
        chk("t4_lasts", 32'(lasts), 32'd2);
        if (recv.size() == 32) begin
            chk("t4_last16", 32'(recv[15][8]), 32'd1);
            chk("t4_last32", 32'(recv[31][8]), 32'd1);
        end

        // 5: warm-up bytes ignored, then zero-length frame
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        idle(2);
        chk("t5_quiet_cnt", 32'(frame_cnt), 32'd5);
        frm = '{8'hA5, 8'h00, 8'h00};
        send_frm(0);
        chk("t5_ok",    32'(frame_ok),  32'd1);
        chk("t5_cnt",   32'(frame_cnt), 32'd6);
        chk("t5_valid", 32'(bus_if.out_valid), 32'd0);

        // 6a: reset mid-frame, then a full frame
        frm = '{8'hA5, 8'h03, 8'h11};
        send_frm(0);
        #2 rst_n = 1'b0;
        idle(2);
        chk("t6_rst_cnt",   32'(frame_cnt), 32'd0);
        chk("t6_rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("t6_rst_data",  32'(bus_if.out_data), 32'd0);
        #2 rst_n = 1'b1;
        idle(4);
        frm = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_frm(0);
        chk("t6_ok", 32'(frame_ok), 32'd1);
        drain();
        chk("t6_cnt1", 32'(frame_cnt), 32'd1);

        // 6b: 100 frames with random backpressure across pointer wrap
        recv.delete();
        rnd_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            build(5, f * 5);
            send_frm(1);
        end
        rnd_ready = 1'b0;
        drain();
        chk("t6_nrx", 32'(recv.size()), 32'd500);
        errs = 0;
        foreach (recv[j]) begin
            if (recv[j][7:0] != 8'(j)) errs++;
            if (recv[j][8] != ((j % 5) == 4)) errs++;
        end
        chk("t6_order", 32'(errs), 32'd0);
        chk("t6_cnt", 32'(frame_cnt), 32'd101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
